// File: rtl/simon_input_checker.sv
// simon_input_checker
//   Player-input side of the Simon Says game. Debounces the four game
//   buttons on the divider tick, turns a 0000->nonzero change of the
//   debounced vector into a single key event, and checks each key against
//   the expected sequence held in an external store.
//
// Ports
//   clk       : system clock
//   reset     : synchronous, active-high reset
//   tick      : one-clk sample enable from the clock divider
//   btn       : raw buttons, btn[i] encodes key code i
//   start     : one-clk pulse, begins an entry round (len sampled here)
//   len       : entries expected this round, valid 1..MAXLEN
//   exp_addr  : registered index into the sequence store
//   exp_val   : expected key code at exp_addr (combinational store read)
//   busy      : high while a round is active
//   key_pulse : one-clk pulse per accepted correct key
//   last_key  : code of the most recent key event
//   count     : correct keys accepted this round
//   pass      : one-clk pulse, all len keys correct
//   fail      : one-clk pulse, wrong key, multi-key, timeout or bad len
module simon_input_checker #(
  parameter int MAXLEN    = 16,
  parameter int DEB_TICKS = 4,
  parameter int TIMEOUT   = 1000,
  localparam int PTR_W    = $clog2(MAXLEN),
  localparam int LEN_W    = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [3:0]       btn,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic [PTR_W-1:0] exp_addr,
  input  logic [1:0]       exp_val,
  output logic             busy,
  output logic             key_pulse,
  output logic [1:0]       last_key,
  output logic [LEN_W-1:0] count,
  output logic             pass,
  output logic             fail
);

  localparam int CNT_W = $clog2(DEB_TICKS);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              stb_q, stb_d;
  logic [3:0]              stb_prev_q;
  logic [3:0][CNT_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [PTR_W-1:0]        addr_q, addr_d;
  logic [LEN_W-1:0]        count_q, count_d;
  logic [1:0]              last_key_q, last_key_d;
  logic                    key_pulse_q, key_pulse_d;
  logic                    pass_q, pass_d;
  logic                    fail_q, fail_d;

  logic                    key_evt;
  logic                    multi;
  logic [1:0]              key_code;
  logic                    len_ok;
  logic                    tmo;

  // Debounce: a button flips only after DEB_TICKS consecutive ticks that
  // disagree with its debounced value; any agreeing tick restarts the count.
  always_comb begin
    stb_d     = stb_q;
    deb_cnt_d = deb_cnt_q;
    if (tick) begin
      for (int i = 0; i < 4; i++) begin
        if (btn[i] == stb_q[i]) begin
          deb_cnt_d[i] = '0;
        end else if (deb_cnt_q[i] == CNT_W'(DEB_TICKS - 1)) begin
          stb_d[i]     = ~stb_q[i];
          deb_cnt_d[i] = '0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // A key event is the first cycle the debounced vector is nonzero after
  // having been all-zero; holding or adding buttons gives no further event.
  assign key_evt = (stb_q != 4'b0000) && (stb_prev_q == 4'b0000);
  assign multi   = (stb_q & (stb_q - 4'd1)) != 4'b0000;

  // Lowest set bit wins; only meaningful as a code when exactly one is set.
  always_comb begin
    key_code = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (stb_q[i]) key_code = 2'(i);
    end
  end

  assign len_ok = (len != '0) && (len <= LEN_W'(MAXLEN));
  assign tmo    = tick && (timer_q == TMR_W'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    len_d       = len_q;
    addr_d      = addr_q;
    count_d     = count_q;
    last_key_d  = last_key_q;
    key_pulse_d = 1'b0;
    pass_d      = 1'b0;
    fail_d      = 1'b0;

    if (key_evt) last_key_d = key_code;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_d = WAIT_PRESS;
            addr_d  = '0;
            count_d = '0;
            timer_d = '0;
            len_d   = len;
          end else begin
            fail_d = 1'b1;
          end
        end
      end
      WAIT_PRESS: begin
        // A key event takes priority over a coincident tick, so the timer
        // is simply cleared rather than incremented.
        if (key_evt) begin
          timer_d = '0;
          if (!multi && (key_code == exp_val)) begin
            key_pulse_d = 1'b1;
            count_d     = count_q + LEN_W'(1);
            if ((count_q + LEN_W'(1)) == len_q) begin
              pass_d  = 1'b1;
              state_d = IDLE;
            end else begin
              addr_d  = addr_q + PTR_W'(1);
              state_d = WAIT_RELEASE;
            end
          end else begin
            fail_d  = 1'b1;
            state_d = IDLE;
          end
        end else if (tmo) begin
          fail_d  = 1'b1;
          state_d = IDLE;
        end else if (tick) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      WAIT_RELEASE: begin
        if (stb_q == 4'b0000) begin
          state_d = WAIT_PRESS;
          timer_d = '0;
        end else if (tmo) begin
          fail_d  = 1'b1;
          state_d = IDLE;
        end else if (tick) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      stb_q       <= '0;
      stb_prev_q  <= '0;
      deb_cnt_q   <= '0;
      timer_q     <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      last_key_q  <= '0;
      key_pulse_q <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stb_q       <= stb_d;
      stb_prev_q  <= stb_q;
      deb_cnt_q   <= deb_cnt_d;
      timer_q     <= timer_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      last_key_q  <= last_key_d;
      key_pulse_q <= key_pulse_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
    end
  end

  assign exp_addr  = addr_q;
  assign busy      = (state_q != IDLE);
  assign key_pulse = key_pulse_q;
  assign last_key  = last_key_q;
  assign count     = count_q;
  assign pass      = pass_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_simon_input_checker.sv
// Directed bench for simon_input_checker (MAXLEN=16, DEB_TICKS=4, TIMEOUT=10).
module tb_simon_input_checker;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset, tick, start;
  logic [3:0] btn;
  logic [4:0] len;
  logic [3:0] exp_addr;
  logic [1:0] exp_val;
  logic       busy, key_pulse, pass, fail;
  logic [1:0] last_key;
  logic [4:0] count;
  logic [1:0] seq [16];

  int total = 0, bad = 0;
  int kp_cnt = 0, pass_cnt = 0, fail_cnt = 0, both_cnt = 0;
  int k0, p0, f0;

  simon_input_checker #(.MAXLEN(16), .DEB_TICKS(DEB), .TIMEOUT(10)) dut (
    .clk(clk), .reset(reset), .tick(tick), .btn(btn), .start(start),
    .len(len), .exp_addr(exp_addr), .exp_val(exp_val), .busy(busy),
    .key_pulse(key_pulse), .last_key(last_key), .count(count),
    .pass(pass), .fail(fail)
  );

  assign exp_val = seq[exp_addr];

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_pulse) kp_cnt++;
    if (pass) pass_cnt++;
    if (fail) fail_cnt++;
    if (pass && fail) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  task automatic press(input logic [3:0] mask);
    btn = mask;
    repeat (DEB) tick_once();
  endtask

  task automatic rel();
    btn = 4'b0000;
    repeat (DEB) tick_once();
  endtask

  task automatic go(input logic [4:0] l);
    len   = l;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; start = 1'b0; btn = 4'b0000; len = '0;
    for (int i = 0; i < 16; i++) seq[i] = 2'd0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_addr", exp_addr, 0);
    chk("rst_count", count, 0);
    chk("rst_last", last_key, 0);
    chk("rst_pulses", {key_pulse, pass, fail}, 0);

    // Glitch shorter than DEB_TICKS, then 3 more ticks: no event either time.
    btn = 4'b0100;
    repeat (3) tick_once();
    btn = 4'b0000;
    repeat (6) tick_once();
    chk("glitch_last", last_key, 0);
    btn = 4'b0100;
    repeat (3) tick_once();
    step();
    chk("deb3_last", last_key, 0);
    tick_once();
    chk("deb4_last", last_key, 2);
    rel();
    chk("glitch_kp", kp_cnt, 0);

    // Correct round {1,3,0}.
    seq[0] = 2'd1; seq[1] = 2'd3; seq[2] = 2'd0;
    k0 = kp_cnt; p0 = pass_cnt; f0 = fail_cnt;
    go(5'd3);
    chk("p_busy", busy, 1);
    chk("p_addr0", exp_addr, 0);
    press(4'b0010);
    chk("p1_kp", key_pulse, 1);
    chk("p1_count", count, 1);
    chk("p1_addr", exp_addr, 1);
    chk("p1_last", last_key, 1);
    rel();
    press(4'b1000);
    chk("p2_count", count, 2);
    chk("p2_addr", exp_addr, 2);
    rel();
    press(4'b0001);
    chk("p3_pass", pass, 1);
    chk("p3_kp", key_pulse, 1);
    chk("p3_count", count, 3);
    chk("p3_addr", exp_addr, 2);
    chk("p3_busy", busy, 0);
    rel();
    chk("p_kp_total", kp_cnt - k0, 3);
    chk("p_pass_total", pass_cnt - p0, 1);
    chk("p_fail_total", fail_cnt - f0, 0);

    // Wrong key on second entry of {2,2}.
    seq[0] = 2'd2; seq[1] = 2'd2;
    k0 = kp_cnt;
    go(5'd2);
    press(4'b0100);
    chk("w1_count", count, 1);
    rel();
    press(4'b0010);
    chk("w2_fail", fail, 1);
    chk("w2_kp", key_pulse, 0);
    chk("w2_count", count, 1);
    chk("w2_last", last_key, 1);
    chk("w2_busy", busy, 0);
    rel();
    chk("w_kp_total", kp_cnt - k0, 1);

    // Multi-key whose lowest bit matches the expected code still fails.
    seq[0] = 2'd0;
    go(5'd2);
    press(4'b0101);
    chk("m_fail", fail, 1);
    chk("m_kp", key_pulse, 0);
    chk("m_busy", busy, 0);
    chk("m_count", count, 0);
    rel();

    // Bad lengths.
    go(5'd0);
    chk("len0_fail", fail, 1);
    chk("len0_busy", busy, 0);
    go(5'd17);
    chk("len17_fail", fail, 1);
    chk("len17_busy", busy, 0);

    // len=16 accepted; mid-round start ignored; timeout on 10th tick.
    seq[0] = 2'd3;
    go(5'd16);
    chk("t_busy", busy, 1);
    press(4'b1000);
    chk("t_addr", exp_addr, 1);
    rel();
    go(5'd3);
    chk("t_restart_addr", exp_addr, 1);
    chk("t_restart_count", count, 1);
    chk("t_restart_busy", busy, 1);
    f0 = fail_cnt;
    repeat (9) tick_once();
    chk("t9_fail", fail_cnt - f0, 0);
    chk("t9_busy", busy, 1);
    tick_once();
    chk("t10_fail", fail_cnt - f0, 1);
    chk("t10_busy", busy, 0);

    // Reset after 2 of 4 correct keys.
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3;
    go(5'd4);
    press(4'b0001);
    rel();
    press(4'b0010);
    chk("r_count2", count, 2);
    p0 = pass_cnt; f0 = fail_cnt;
    reset = 1'b1;
    btn   = 4'b0000;
    step();
    chk("r_busy", busy, 0);
    chk("r_count", count, 0);
    chk("r_addr", exp_addr, 0);
    chk("r_last", last_key, 0);
    chk("r_pulses", {key_pulse, pass, fail}, 0);
    reset = 1'b0;
    step();
    step();
    chk("r_no_passfail", (pass_cnt - p0) + (fail_cnt - f0), 0);
    go(5'd1);
    press(4'b0001);
    chk("r_fresh_pass", pass, 1);
    chk("r_fresh_count", count, 1);
    rel();

    chk("pass_fail_excl", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
